// File: rtl/cache_pkg.sv
// Shared definitions for the n-way cache controller.
//   DEF_WAYS      : default associativity
//   state_t       : controller FSM state encoding
//   first_invalid : lowest-index way whose valid bit is clear, -1 if none
//   onehot_to_idx : binary index of a one-hot way vector
package cache_pkg;

  localparam int DEF_WAYS = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITEBACK = 3'd1,
    ST_WB_GAP    = 3'd2,
    ST_ALLOCATE  = 3'd3,
    ST_BACKOFF   = 3'd4
  } state_t;

  // Vectors are zero-extended to 16 bits by the caller; only the low
  // 'ways' bits are considered.  Descending scan leaves the lowest hit.
  function automatic int first_invalid(input logic [15:0] valid, input int ways);
    int r;
    r = -1;
    for (int i = 15; i >= 0; i--) begin
      if (i < ways && !valid[i]) r = i;
    end
    return r;
  endfunction

  function automatic int onehot_to_idx(input logic [15:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) r = r | i;
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Victim way selection for a cache miss (purely combinational).
//   valid_vec   in  : per-way valid bits of the indexed set
//   plru_victim in  : pseudo-LRU victim of the indexed set
//   victim      out : lowest invalid way if any, else the PLRU victim
module cache_victim_sel
  import cache_pkg::*;
#(
  parameter int WAYS = DEF_WAYS,
  localparam int WAY_BITS = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]     valid_vec,
  input  logic [WAY_BITS-1:0] plru_victim,
  output logic [WAY_BITS-1:0] victim
);

  int w_first;

  assign w_first = first_invalid(16'(valid_vec), WAYS);
  assign victim  = (w_first >= 0) ? WAY_BITS'(w_first) : plru_victim;

endmodule

// File: rtl/cache_control_nway.sv
// Control FSM for an n-way set-associative write-back cache.
// Hits complete in IDLE in the same cycle; a miss optionally writes the
// dirty victim back, then allocates (fills) the victim way from memory.
// Memory retries back off one cycle and are bounded by MAX_RETRY.
//   clk, rst_n                  : clock, async active-low reset
//   cpu_cyc/stb/we, cpu_ack/err : CPU wishbone slave side
//   hit_vec/valid_vec/dirty_vec : per-way status of the indexed set
//   plru_victim, plru_update/way: pseudo-LRU interface
//   way/valid/dirty_write, valid_in/dirty_in : array write strobes
//   datain_sel, memaddr_sel, load_mar/mdr    : datapath steering
//   mem_cyc/stb/we, mem_ack/rty : memory wishbone master side
module cache_control_nway
  import cache_pkg::*;
#(
  parameter int WAYS      = DEF_WAYS,
  parameter int MAX_RETRY = 3,
  localparam int WAY_BITS = $clog2(WAYS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_cyc,
  input  logic                cpu_stb,
  input  logic                cpu_we,
  output logic                cpu_ack,
  output logic                cpu_err,
  input  logic [WAYS-1:0]     hit_vec,
  input  logic [WAYS-1:0]     valid_vec,
  input  logic [WAYS-1:0]     dirty_vec,
  input  logic [WAY_BITS-1:0] plru_victim,
  output logic [WAYS-1:0]     way_write,
  output logic [WAYS-1:0]     valid_write,
  output logic [WAYS-1:0]     dirty_write,
  output logic                valid_in,
  output logic                dirty_in,
  output logic                plru_update,
  output logic [WAY_BITS-1:0] plru_way,
  output logic                datain_sel,
  output logic                memaddr_sel,
  output logic                load_mar,
  output logic                load_mdr,
  output logic                mem_cyc,
  output logic                mem_stb,
  output logic                mem_we,
  input  logic                mem_ack,
  input  logic                mem_rty
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  state_t               r_state;
  logic [WAY_BITS-1:0]  r_victim;
  logic [RETRY_W-1:0]   r_retry;
  logic                 r_ret_alloc;   // 1: BACKOFF returns to ALLOCATE

  state_t               w_state_nxt;
  logic [WAY_BITS-1:0]  w_victim_nxt;
  logic [RETRY_W-1:0]   w_retry_nxt;
  logic                 w_ret_alloc_nxt;
  logic [WAY_BITS-1:0]  w_victim_sel;
  logic [WAY_BITS-1:0]  w_hit_idx;
  logic [WAYS-1:0]      w_hit_oh;
  logic [WAYS-1:0]      w_vic_oh;
  logic                 w_req;
  logic                 w_retry_max;

  cache_victim_sel #(.WAYS(WAYS)) u_victim_sel (
    .valid_vec   (valid_vec),
    .plru_victim (plru_victim),
    .victim      (w_victim_sel)
  );

  assign w_req       = cpu_cyc & cpu_stb;
  assign w_hit_idx   = WAY_BITS'(onehot_to_idx(16'(hit_vec)));
  assign w_hit_oh    = WAYS'(1) << w_hit_idx;
  assign w_vic_oh    = WAYS'(1) << r_victim;
  assign w_retry_max = (r_retry == RETRY_W'(MAX_RETRY));

  always_comb begin
    cpu_ack         = 1'b0;
    cpu_err         = 1'b0;
    way_write       = '0;
    valid_write     = '0;
    dirty_write     = '0;
    valid_in        = 1'b0;
    dirty_in        = 1'b0;
    plru_update     = 1'b0;
    plru_way        = '0;
    datain_sel      = 1'b0;
    memaddr_sel     = 1'b0;
    load_mar        = 1'b0;
    load_mdr        = 1'b0;
    mem_cyc         = 1'b0;
    mem_stb         = 1'b0;
    mem_we          = 1'b0;
    w_state_nxt     = r_state;
    w_victim_nxt    = r_victim;
    w_retry_nxt     = r_retry;
    w_ret_alloc_nxt = r_ret_alloc;
    // Outputs are combinational on inputs in IDLE, so gate them during
    // reset to keep the whole interface quiet.
    if (rst_n) begin
      case (r_state)
        ST_IDLE: begin
          if (w_req && |hit_vec) begin
            cpu_ack     = 1'b1;
            plru_update = 1'b1;
            plru_way    = w_hit_idx;
            if (cpu_we) begin
              datain_sel  = 1'b1;
              way_write   = w_hit_oh;
              valid_write = w_hit_oh;
              dirty_write = w_hit_oh;
              valid_in    = 1'b1;
              dirty_in    = 1'b1;
            end
          end else if (w_req) begin
            w_victim_nxt = w_victim_sel;
            w_retry_nxt  = '0;
            if (valid_vec[w_victim_sel] && dirty_vec[w_victim_sel])
              w_state_nxt = ST_WRITEBACK;
            else
              w_state_nxt = ST_ALLOCATE;
          end
        end
        ST_WRITEBACK: begin
          mem_cyc     = 1'b1;
          mem_stb     = 1'b1;
          mem_we      = 1'b1;
          memaddr_sel = 1'b1;
          load_mar    = 1'b1;
          load_mdr    = 1'b1;
          if (mem_ack) begin
            w_state_nxt = ST_WB_GAP;
          end else if (mem_rty) begin
            if (w_retry_max) begin
              cpu_err     = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_retry_nxt     = r_retry + 1'b1;
              w_ret_alloc_nxt = 1'b0;
              w_state_nxt     = ST_BACKOFF;
            end
          end
        end
        ST_WB_GAP: begin
          w_state_nxt = ST_ALLOCATE;
        end
        ST_ALLOCATE: begin
          mem_cyc  = 1'b1;
          mem_stb  = 1'b1;
          load_mar = 1'b1;
          if (mem_ack) begin
            way_write   = w_vic_oh;
            valid_write = w_vic_oh;
            dirty_write = w_vic_oh;
            valid_in    = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (mem_rty) begin
            if (w_retry_max) begin
              cpu_err     = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_retry_nxt     = r_retry + 1'b1;
              w_ret_alloc_nxt = 1'b1;
              w_state_nxt     = ST_BACKOFF;
            end
          end
        end
        ST_BACKOFF: begin
          w_state_nxt = r_ret_alloc ? ST_ALLOCATE : ST_WRITEBACK;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_victim    <= '0;
      r_retry     <= '0;
      r_ret_alloc <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_victim    <= w_victim_nxt;
      r_retry     <= w_retry_nxt;
      r_ret_alloc <= w_ret_alloc_nxt;
    end
  end

endmodule

// File: tb/tb_cache_control_nway.sv
module tb_cache_control_nway;

  logic       clk;
  logic       rst_n;
  logic       cpu_cyc, cpu_stb, cpu_we;
  logic       cpu_ack, cpu_err;
  logic [3:0] hit_vec, valid_vec, dirty_vec;
  logic [1:0] plru_victim;
  logic [3:0] way_write, valid_write, dirty_write;
  logic       valid_in, dirty_in, plru_update;
  logic [1:0] plru_way;
  logic       datain_sel, memaddr_sel, load_mar, load_mdr;
  logic       mem_cyc, mem_stb, mem_we, mem_ack, mem_rty;

  int checks = 0;
  int errors = 0;

  // Expected array/CPU event: {ack, err, way_write, valid_write, dirty_write,
  // valid_in, dirty_in, plru_update, plru_way, datain_sel}
  logic [19:0] exp_q[$];

  cache_control_nway #(.WAYS(4), .MAX_RETRY(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_cyc(cpu_cyc), .cpu_stb(cpu_stb), .cpu_we(cpu_we),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec),
    .plru_victim(plru_victim),
    .way_write(way_write), .valid_write(valid_write), .dirty_write(dirty_write),
    .valid_in(valid_in), .dirty_in(dirty_in),
    .plru_update(plru_update), .plru_way(plru_way),
    .datain_sel(datain_sel), .memaddr_sel(memaddr_sel),
    .load_mar(load_mar), .load_mdr(load_mdr),
    .mem_cyc(mem_cyc), .mem_stb(mem_stb), .mem_we(mem_we),
    .mem_ack(mem_ack), .mem_rty(mem_rty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [25:0] all_outs();
    return {cpu_ack, cpu_err, way_write, valid_write, dirty_write, valid_in,
            dirty_in, plru_update, plru_way, datain_sel, memaddr_sel,
            load_mar, load_mdr, mem_cyc, mem_stb, mem_we};
  endfunction

  function automatic logic [19:0] evt_now();
    return {cpu_ack, cpu_err, way_write, valid_write, dirty_write, valid_in,
            dirty_in, plru_update, plru_way, datain_sel};
  endfunction

  task automatic push_exp(input logic ack, input logic err, input logic [3:0] w,
                          input logic vi, input logic di, input logic pu,
                          input logic [1:0] pw, input logic ds);
    exp_q.push_back({ack, err, w, w, w, vi, di, pu, pw, ds});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic miss_req(input logic [3:0] vv, input logic [3:0] dv, input logic [1:0] pv);
    cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b0;
    hit_vec = 4'b0000; valid_vec = vv; dirty_vec = dv; plru_victim = pv;
  endtask

  task automatic drop_req();
    cpu_cyc = 1'b0; cpu_stb = 1'b0; cpu_we = 1'b0; hit_vec = 4'b0000;
  endtask

  // Monitor: any CPU or array event pops and compares the next expectation.
  always @(negedge clk) begin
    if (rst_n && (cpu_ack || cpu_err || (|way_write) || (|valid_write) ||
                  (|dirty_write) || plru_update)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got %0h expected none", evt_now());
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        if (evt_now() !== e) begin
          errors++;
          $display("FAIL event: got %0h expected %0h", evt_now(), e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    mem_ack = 1'b0; mem_rty = 1'b0;
    valid_vec = 4'hF; dirty_vec = 4'h0; plru_victim = 2'd0;
    // Request with a hit presented during reset must stay silent.
    cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b1; hit_vec = 4'b0001;
    step();
    chk("reset_outs", 32'(all_outs()), 32'h0);
    step();
    rst_n = 1'b1;
    drop_req();
    step();
    chk("idle_outs", 32'(all_outs()), 32'h0);

    // Hits: read way 0, write way 2, read way 3.
    cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b0; hit_vec = 4'b0001;
    push_exp(1, 0, 4'b0000, 0, 0, 1, 2'd0, 0);
    step();
    cpu_we = 1'b1; hit_vec = 4'b0100;
    push_exp(1, 0, 4'b0100, 1, 1, 1, 2'd2, 1);
    step();
    cpu_we = 1'b0; hit_vec = 4'b1000;
    push_exp(1, 0, 4'b0000, 0, 0, 1, 2'd3, 0);
    step();
    // cpu_stb low alone is not a request.
    cpu_stb = 1'b0;
    step();
    chk("no_stb_outs", 32'(all_outs()), 32'h0);
    drop_req();
    step();

    // Clean miss, invalid way 2 becomes victim, ack on third ALLOCATE cycle.
    miss_req(4'b1011, 4'b0000, 2'd0);
    step();
    chk("alloc_mem", 32'({mem_cyc, mem_stb, mem_we, load_mar, load_mdr}), 32'b11010);
    step();
    step();
    push_exp(0, 0, 4'b0100, 1, 0, 0, 2'd0, 0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0; hit_vec = 4'b0100;
    chk("post_fill_mem", 32'(mem_cyc), 32'h0);
    push_exp(1, 0, 4'b0000, 0, 0, 1, 2'd2, 0);
    step();
    drop_req();
    step();

    // Dirty PLRU victim 1: writeback, one gap cycle, then fill way 1.
    miss_req(4'hF, 4'b0010, 2'd1);
    step();
    chk("wb_mem", 32'({mem_cyc, mem_stb, mem_we, memaddr_sel, load_mar, load_mdr}), 32'b111111);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("wb_gap_mem", 32'({mem_cyc, mem_stb, mem_we, memaddr_sel, load_mar, load_mdr}), 32'h0);
    step();
    chk("alloc2_mem", 32'({mem_cyc, mem_stb, mem_we, memaddr_sel}), 32'b1100);
    push_exp(0, 0, 4'b0010, 1, 0, 0, 2'd0, 0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0; hit_vec = 4'b0010;
    push_exp(1, 0, 4'b0000, 0, 0, 1, 2'd1, 0);
    step();
    drop_req();
    step();

    // Retry exhaustion in ALLOCATE: three backoffs, fourth rty errors.
    miss_req(4'b0111, 4'b0000, 2'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      mem_rty = 1'b1;
      step();
      mem_rty = 1'b0;
      chk("backoff_cyc", 32'({mem_cyc, mem_stb}), 32'h0);
      step();
      chk("retry_alloc_cyc", 32'({mem_cyc, mem_stb, mem_we}), 32'b110);
    end
    push_exp(0, 1, 4'b0000, 0, 0, 0, 2'd0, 0);
    mem_rty = 1'b1;
    step();
    mem_rty = 1'b0;
    drop_req();
    chk("after_err_outs", 32'(all_outs()), 32'h0);
    step();

    // Simultaneous ack and rty: ack wins, fill way 0.
    miss_req(4'b1110, 4'b0000, 2'd3);
    step();
    push_exp(0, 0, 4'b0001, 1, 0, 0, 2'd0, 0);
    mem_ack = 1'b1; mem_rty = 1'b1;
    step();
    mem_ack = 1'b0; mem_rty = 1'b0; hit_vec = 4'b0001;
    push_exp(1, 0, 4'b0000, 0, 0, 1, 2'd0, 0);
    step();
    drop_req();
    step();

    // Request dropped mid-miss: fill still happens, no cpu_ack.
    miss_req(4'b1101, 4'b0000, 2'd0);
    step();
    drop_req();
    step();
    push_exp(0, 0, 4'b0010, 1, 0, 0, 2'd0, 0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("drop_idle_outs", 32'(all_outs()), 32'h0);
    step();

    // Writeback retry returns to WRITEBACK, then reset mid-writeback.
    miss_req(4'hF, 4'b1000, 2'd3);
    step();
    mem_rty = 1'b1;
    step();
    mem_rty = 1'b0;
    chk("wb_backoff_cyc", 32'(mem_cyc), 32'h0);
    step();
    chk("wb_return", 32'({mem_cyc, mem_we, memaddr_sel}), 32'b111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_drop_cyc", 32'({mem_cyc, mem_stb}), 32'h0);
    chk("reset_mid_outs", 32'(all_outs()), 32'h0);
    step();
    rst_n = 1'b1;
    drop_req();
    step();
    chk("post_reset_outs", 32'(all_outs()), 32'h0);
    cpu_cyc = 1'b1; cpu_stb = 1'b1; hit_vec = 4'b0001;
    push_exp(1, 0, 4'b0000, 0, 0, 1, 2'd0, 0);
    step();
    drop_req();
    step();
    step();

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_control_nway.md
CACHE_CONTROL_NWAY -- requirements
Module: cache_control_nway

Interface
REQ-001 Parameter WAYS, default 4, associativity; SHALL be a power of two, 2..16.
REQ-002 Parameter MAX_RETRY, default 3, memory retries allowed per miss before error.
REQ-003 Localparam WAY_BITS = $clog2(WAYS).
REQ-004 Ports SHALL be, clock and reset first:
clk  in  1  clock; one clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
cpu_cyc, cpu_stb, cpu_we  in  1 each  CPU wishbone request
cpu_ack  out  1  request complete
cpu_err  out  1  miss abandoned after retries exhausted
hit_vec  in  WAYS  per-way tag match of indexed set
valid_vec, dirty_vec  in  WAYS  per-way valid/dirty of indexed set
plru_victim  in  WAY_BITS  pseudo-LRU victim of indexed set
way_write  out  WAYS  one-hot data/tag array write
valid_write, dirty_write  out  WAYS  one-hot bit-array writes
valid_in, dirty_in  out  1  values written
plru_update  out  1  touch PLRU
plru_way  out  WAY_BITS  way touched
datain_sel  out  1  1 = CPU write data, 0 = memory data
memaddr_sel  out  1  1 = victim tag address, 0 = CPU address
load_mar, load_mdr  out  1  memory address/data register loads
mem_cyc, mem_stb, mem_we  out  1  memory wishbone master
mem_ack, mem_rty  in  1  memory wishbone responses

Function
REQ-005 States SHALL be IDLE, WRITEBACK, WB_GAP, ALLOCATE, BACKOFF; all outputs Moore/Mealy-combinational, default 0.
REQ-006 IDLE, cpu_cyc&cpu_stb, |hit_vec: cpu_ack=1 same cycle; plru_update=1, plru_way=index of hit way; stay IDLE.
REQ-007 IDLE hit with cpu_we: datain_sel=1, way_write, valid_write, dirty_write asserted for hit way, valid_in=dirty_in=1.
REQ-008 IDLE miss: victim = lowest-index way with valid_vec=0, else plru_victim; victim latched into victim_q.
REQ-009 Miss transition: victim valid and dirty -> WRITEBACK, else -> ALLOCATE; retry counter cleared.
REQ-010 WRITEBACK: mem_cyc=mem_stb=mem_we=1, memaddr_sel=1, load_mar=load_mdr=1; on mem_ack -> WB_GAP.
REQ-011 WB_GAP: all memory outputs 0 for exactly one cycle, then -> ALLOCATE.
REQ-012 ALLOCATE: mem_cyc=mem_stb=1, mem_we=0, load_mar=1; way_write/valid_write/dirty_write for victim_q, valid_in=1, dirty_in=0 asserted only in the mem_ack cycle; on mem_ack -> IDLE.
REQ-013 After fill, IDLE re-evaluates the still-held request, which hits; cpu_ack is never asserted outside IDLE.
REQ-014 mem_rty without mem_ack in WRITEBACK/ALLOCATE: counter increments, -> BACKOFF (cyc/stb low one cycle), then back to originating state, recorded in a return flag.
REQ-015 mem_rty when counter == MAX_RETRY: -> IDLE, cpu_err=1 for that one cycle, no array writes.
REQ-016 mem_ack and mem_rty simultaneously: ack takes precedence.
REQ-017 cpu_cyc or cpu_stb dropped mid-miss: memory sequence still completes, including fill; no cpu_ack issued.
REQ-018 plru_way width WAY_BITS; counter width $clog2(MAX_RETRY+1); no overflow possible.

Reset
REQ-019 rst_n low SHALL asynchronously force state IDLE, victim_q=0, retry counter=0, return flag=0.
REQ-020 During reset and in IDLE with no request, every output SHALL be 0.
REQ-021 Reset mid-WRITEBACK/ALLOCATE SHALL drop mem_cyc/mem_stb immediately; no array write occurs.

Structure
REQ-022 Package cache_pkg SHALL hold the state enum, default WAYS, and the first-invalid/one-hot-to-index functions.
REQ-023 Sub-module cache_victim_sel (combinational: valid_vec, plru_victim -> victim index) SHALL be instantiated once.

Verification
REQ-024 WAYS=4, hit_vec=4'b0100, cpu_we=1 -> same-cycle cpu_ack, way_write=4'b0100, dirty_in=1, plru_way=2.
REQ-025 Miss, valid_vec=4'b1011 -> victim 2, ALLOCATE, mem_ack after 3 cycles -> way_write=4'b0100 only in ack cycle; cpu_ack next cycle when hit_vec=4'b0100.
REQ-026 Miss, valid_vec=4'hF, plru_victim=1, dirty_vec=4'b0010 -> WRITEBACK (mem_we=1), ack -> one WB_GAP cycle -> ALLOCATE -> fill way 1.
REQ-027 MAX_RETRY=3, mem_rty on every ALLOCATE attempt -> 3 BACKOFF cycles, fourth rty -> cpu_err pulse, IDLE, no writes.
REQ-028 mem_ack=mem_rty=1 in ALLOCATE -> fill completes, no BACKOFF.
REQ-029 rst_n low mid-WRITEBACK -> mem_cyc=0 before next clock edge; after release, state IDLE, all outputs 0.
